// File: rtl/encoder_pkg.sv
// Shared constants and checks for encoder_m_to_n.
// Round-robin selection is enabled by defining ENCODER_ROUND_ROBIN_EN.
package encoder_pkg;

  localparam int CODE_RST = 0;
  localparam int PTR_RST  = 0;

  function automatic bit width_ok(input int n_in, input int n_out);
    return n_in == (1 << n_out);
  endfunction

endpackage

// File: rtl/lowest_set_finder.sv
// Combinational lowest-set-bit locator.
// Reports the binary index of the lowest set bit and whether any bit is set.
module lowest_set_finder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Descending scan so the lowest set bit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_m_to_n.sv
// Registered request encoder: sticky pending set drained as binary codes.
// Define ENCODER_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module encoder_m_to_n
  import encoder_pkg::*;
#(
  parameter int NUMBER_OF_INPUT  = 8,
  parameter int NUMBER_OF_OUTPUT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUMBER_OF_INPUT-1:0]  req,
  input  logic                        enable,
  output logic [NUMBER_OF_OUTPUT-1:0] code,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [NUMBER_OF_INPUT-1:0]  pending,
  output logic                        busy
);

  localparam int N = NUMBER_OF_INPUT;
  localparam int W = NUMBER_OF_OUTPUT;

  if (!width_ok(N, W)) begin : g_bad_width
    $error("NUMBER_OF_INPUT must equal 2**NUMBER_OF_OUTPUT");
  end

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [N-1:0] load_mask;
  logic [W-1:0] code_q;
  logic         valid_q;
  logic         stage_free;
  logic         load;
  logic [W-1:0] sel;
  logic         found;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q;
  logic [N-1:0] gt_mask;
  logic [W-1:0] idx_m;
  logic [W-1:0] idx_a;
  logic         found_m;

  always_comb begin
    gt_mask = '0;
    for (int i = 0; i < N; i++) begin
      gt_mask[i] = (i > int'(ptr_q));
    end
  end

  lowest_set_finder #(.N(N), .W(W)) u_find_m (
    .vec   (pend_q & gt_mask),
    .idx   (idx_m),
    .found (found_m)
  );

  lowest_set_finder #(.N(N), .W(W)) u_find_a (
    .vec   (pend_q),
    .idx   (idx_a),
    .found (found)
  );

  // Prefer indices above the last grant, else wrap to the lowest.
  assign sel = found_m ? idx_m : idx_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= W'(PTR_RST);
    end else if (load) begin
      ptr_q <= sel;
    end
  end
`else
  lowest_set_finder #(.N(N), .W(W)) u_find (
    .vec   (pend_q),
    .idx   (sel),
    .found (found)
  );
`endif

  assign stage_free = !valid_q || code_ready;
  assign load       = stage_free && found;

  // Set dominates clear so a same-edge re-request stays pending.
  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask[sel] = 1'b1;
    end
    pend_d = (pend_q & ~load_mask) | (enable ? req : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      code_q  <= W'(CODE_RST);
      valid_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (stage_free) begin
        valid_q <= load;
        if (load) begin
          code_q <= sel;
        end
      end
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign pending    = pend_q;
  assign busy       = (|pend_q) || valid_q;

endmodule

// File: tb/tb_encoder_m_to_n.sv
// Self-checking bench for encoder_m_to_n: directed cases plus
// randomized traffic against a behavioural model.
module tb_encoder_m_to_n;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       enable;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic       busy;

  int errors;
  int checks;

  // Behavioural model state.
  logic [7:0] m_pend;
  logic [2:0] m_code;
  logic       m_valid;
  int         m_last;

  encoder_m_to_n #(
    .NUMBER_OF_INPUT  (8),
    .NUMBER_OF_OUTPUT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .enable     (enable),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] p, input int last);
    int start;
`ifdef ENCODER_ROUND_ROBIN_EN
    start = last + 1;
`else
    start = 0;
`endif
    for (int k = 0; k < 8; k++) begin
      if (p[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [7:0] np;
    int         w;
    bit         free;
    if (reset) begin
      m_pend  = '0;
      m_code  = '0;
      m_valid = 1'b0;
      m_last  = 0;
      return;
    end
    free = !m_valid || code_ready;
    w    = free ? pick(m_pend, m_last) : -1;
    np   = m_pend;
    if (w >= 0) np[w] = 1'b0;
    if (enable) np = np | req;
    if (free) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_code = 3'(w);
        m_last = w;
      end
    end
    m_pend = np;
  endtask

  task automatic step(input logic [7:0] r, input logic en,
                      input logic rd, input logic rs);
    req        = r;
    enable     = en;
    code_ready = rd;
    reset      = rs;
    @(posedge clk);
    model_edge();
    #1;
    chk("code_valid", 32'(code_valid), 32'(m_valid));
    chk("code", 32'(code), 32'(m_code));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("busy", 32'(busy), 32'((m_pend != 0) || m_valid));
  endtask

  task automatic do_reset();
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_pend = '0;
    m_code = '0;
    m_valid = 1'b0;
    m_last = 0;
    req = '0;
    enable = 1'b1;
    code_ready = 1'b1;
    reset = 1'b1;

    // Reset state.
    step(8'h00, 1'b1, 1'b1, 1'b1);
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single request, two-cycle latency, one-cycle presentation.
    step(8'h04, 1'b1, 1'b1, 1'b0);
    chk("lat_v1", 32'(code_valid), 0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("lat_v2", 32'(code_valid), 1);
    chk("lat_code", 32'(code), 2);
    chk("lat_pend", 32'(pending), 0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("lat_v3", 32'(code_valid), 0);
    chk("lat_busy", 32'(busy), 0);

    // Multi-hot drain order.
    do_reset();
`ifdef ENCODER_ROUND_ROBIN_EN
    step(8'h10, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("rr_prior", 32'(code), 4);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h92, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("rr_first", 32'(code), 7);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("rr_second", 32'(code), 1);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("rr_third", 32'(code), 4);
`else
    step(8'h92, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("fix_first", 32'(code), 1);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("fix_second", 32'(code), 4);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("fix_third", 32'(code), 7);
`endif
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("drain_done", 32'(code_valid), 0);

    // Backpressure hold with merging.
    do_reset();
    step(8'h01, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("hold_code0", 32'(code), 0);
    step(8'h02, 1'b1, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b0, 1'b0);
    chk("hold_merge", 32'(pending), 8'h02);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("hold_stable", 32'({code_valid, code}), 32'({1'b1, 3'd0}));
    end
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("release_code", 32'(code), 1);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("release_done", 32'(code_valid), 0);

    // Enable low ignores requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 1'b0, 1'b1, 1'b0);
      chk("dis_pend", 32'(pending), 0);
      chk("dis_valid", 32'(code_valid), 0);
    end

    // Same-edge re-request: set dominates clear.
    do_reset();
    step(8'h08, 1'b1, 1'b1, 1'b0);
    step(8'h08, 1'b1, 1'b1, 1'b0);
    chk("redo_code1", 32'(code), 3);
    chk("redo_pend", 32'(pending), 8'h08);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("redo_code2", 32'({code_valid, code}), 32'({1'b1, 3'd3}));
    chk("redo_empty", 32'(pending), 0);

    // Reset mid-operation.
    do_reset();
    step(8'hF0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hF0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst", 32'({code_valid, pending}), 32'({1'b1, 8'hF0}));
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("mid_rst", 32'({code_valid, code, pending, busy}), 0);
    step(8'h00, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
